// File: rtl/param_sync_fifo_if.sv
// Handshake and status bundle for param_sync_fifo. The producer/consumer
// side uses the master modport; the FIFO itself takes the slave modport.
interface param_sync_fifo_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
);
   logic              wr_en;
   logic [DATA_W-1:0] d_in;
   logic              rd_en;
   logic [DATA_W-1:0] d_out;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              underflow;

   modport master (
      output wr_en, d_in, rd_en,
      input  d_out, full, empty, almost_full, almost_empty, count,
             overflow, underflow
   );

   modport slave (
      input  wr_en, d_in, rd_en,
      output d_out, full, empty, almost_full, almost_empty, count,
             overflow, underflow
   );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock parameterised FIFO with registered status flags.
// FWFT=0: d_out loads the head word on the edge that accepts a read.
// FWFT=1: the head word is pre-fetched into d_out; rd_en acknowledges it.
// In FWFT mode the word sitting in d_out still counts toward occupancy, so
// count covers memory words plus the output register, capped at DEPTH.
module param_sync_fifo #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 5,
   parameter int AF_LEVEL = (2**ADDR_W) - 4,
   parameter int AE_LEVEL = 4,
   parameter int FWFT     = 0
) (
   input logic              clk,
   input logic              rst,
   param_sync_fifo_if.slave bus
);
   localparam int              DEPTH     = 2**ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0] AF_CNT    = AF_LEVEL[ADDR_W:0];
   localparam logic [ADDR_W:0] AE_CNT    = AE_LEVEL[ADDR_W:0];
   localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

   logic [DATA_W-1:0] mem [DEPTH];

   // pointers carry a wrap bit above the address
   logic [ADDR_W:0]   wr_ptr;
   logic [ADDR_W:0]   rd_ptr;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W:0]   count_nxt;
   logic [DATA_W-1:0] d_out_q;
   logic              valid_q;
   logic              valid_nxt;
   logic              full_q;
   logic              empty_q;
   logic              af_q;
   logic              ae_q;
   logic              overflow_q;
   logic              underflow_q;

   logic              wr_acc;
   logic              rd_acc;
   logic              mem_rd;
   logic              mem_empty;

   // accept decisions, next occupancy and when the memory head is fetched
   always_comb begin
      wr_acc    = bus.wr_en && !full_q;
      rd_acc    = bus.rd_en && !empty_q;
      mem_empty = (wr_ptr == rd_ptr);
      count_nxt = count_q;
      mem_rd    = 1'b0;
      valid_nxt = valid_q;

      if (wr_acc && !rd_acc) begin
         count_nxt = count_q + ONE;
      end else if (!wr_acc && rd_acc) begin
         count_nxt = count_q - ONE;
      end

      if (FWFT != 0) begin
         // refill the output register when it is idle or being popped;
         // a word written this edge is only visible in memory next edge
         mem_rd = (!valid_q || rd_acc) && !mem_empty;
         if (mem_rd) begin
            valid_nxt = 1'b1;
         end else if (rd_acc) begin
            valid_nxt = 1'b0;
         end
      end else begin
         mem_rd    = rd_acc;
         valid_nxt = (count_nxt != '0);
      end
   end

   // storage array; no reset so it can map onto RAM
   always_ff @(posedge clk) begin
      if (wr_acc && !rst) begin
         mem[wr_ptr[ADDR_W-1:0]] <= bus.d_in;
      end
   end

   // pointers, occupancy, output word and registered flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         d_out_q     <= '0;
         valid_q     <= 1'b0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         af_q        <= 1'b0;
         ae_q        <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + ONE;
         end
         if (mem_rd) begin
            d_out_q <= mem[rd_ptr[ADDR_W-1:0]];
            rd_ptr  <= rd_ptr + ONE;
         end
         count_q     <= count_nxt;
         valid_q     <= valid_nxt;
         empty_q     <= !valid_nxt;
         full_q      <= (count_nxt == DEPTH_CNT);
         af_q        <= (count_nxt >= AF_CNT);
         ae_q        <= (count_nxt <= AE_CNT);
         overflow_q  <= bus.wr_en && full_q;
         underflow_q <= bus.rd_en && empty_q;
      end
   end

   assign bus.d_out        = d_out_q;
   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = af_q;
   assign bus.almost_empty = ae_q;
   assign bus.count        = count_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: a standard-mode and an FWFT-mode instance get
// identical stimulus and are each compared against a queue-based model.
module tb_param_sync_fifo;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;
   localparam int AF     = DEPTH - 4;
   localparam int AE     = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   param_sync_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_std ();
   param_sync_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_fw ();

   param_sync_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FWFT(0)) dut_std (
      .clk (clk),
      .rst (rst),
      .bus (bus_std)
   );

   param_sync_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FWFT(1)) dut_fw (
      .clk (clk),
      .rst (rst),
      .bus (bus_fw)
   );

   always #5 clk = ~clk;

   // reference state
   logic [7:0] q_std [$];
   logic [7:0] q_fw  [$];
   logic [7:0] dout_std, dout_fw;
   logic       ovf_std, unf_std, ovf_fw, unf_fw;
   logic       shown_fw;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      q_std.delete();
      q_fw.delete();
      dout_std = '0;
      dout_fw  = '0;
      ovf_std  = 1'b0;
      unf_std  = 1'b0;
      ovf_fw   = 1'b0;
      unf_fw   = 1'b0;
      shown_fw = 1'b0;
   endtask

   task automatic check_reset_values();
      check_eq("rst_std_count", 32'(bus_std.count), 0);
      check_eq("rst_std_empty", 32'(bus_std.empty), 1);
      check_eq("rst_std_full",  32'(bus_std.full), 0);
      check_eq("rst_std_ae",    32'(bus_std.almost_empty), 1);
      check_eq("rst_std_af",    32'(bus_std.almost_full), 0);
      check_eq("rst_std_ovf",   32'(bus_std.overflow), 0);
      check_eq("rst_std_unf",   32'(bus_std.underflow), 0);
      check_eq("rst_std_dout",  32'(bus_std.d_out), 0);
      check_eq("rst_fw_count",  32'(bus_fw.count), 0);
      check_eq("rst_fw_empty",  32'(bus_fw.empty), 1);
      check_eq("rst_fw_full",   32'(bus_fw.full), 0);
      check_eq("rst_fw_ae",     32'(bus_fw.almost_empty), 1);
      check_eq("rst_fw_af",     32'(bus_fw.almost_full), 0);
      check_eq("rst_fw_ovf",    32'(bus_fw.overflow), 0);
      check_eq("rst_fw_unf",    32'(bus_fw.underflow), 0);
      check_eq("rst_fw_dout",   32'(bus_fw.d_out), 0);
   endtask

   task automatic check_all();
      int ns;
      int nf;
      ns = q_std.size();
      nf = q_fw.size();
      check_eq("std_count", 32'(bus_std.count), ns);
      check_eq("std_full",  32'(bus_std.full), 32'(ns == DEPTH));
      check_eq("std_empty", 32'(bus_std.empty), 32'(ns == 0));
      check_eq("std_af",    32'(bus_std.almost_full), 32'(ns >= AF));
      check_eq("std_ae",    32'(bus_std.almost_empty), 32'(ns <= AE));
      check_eq("std_ovf",   32'(bus_std.overflow), 32'(ovf_std));
      check_eq("std_unf",   32'(bus_std.underflow), 32'(unf_std));
      check_eq("std_dout",  32'(bus_std.d_out), 32'(dout_std));
      check_eq("fw_count",  32'(bus_fw.count), nf);
      check_eq("fw_full",   32'(bus_fw.full), 32'(nf == DEPTH));
      check_eq("fw_empty",  32'(bus_fw.empty), 32'(!shown_fw));
      check_eq("fw_af",     32'(bus_fw.almost_full), 32'(nf >= AF));
      check_eq("fw_ae",     32'(bus_fw.almost_empty), 32'(nf <= AE));
      check_eq("fw_ovf",    32'(bus_fw.overflow), 32'(ovf_fw));
      check_eq("fw_unf",    32'(bus_fw.underflow), 32'(unf_fw));
      if (shown_fw) begin
         check_eq("fw_dout", 32'(bus_fw.d_out), 32'(dout_fw));
      end
   endtask

   // one clock of identical stimulus to both instances, then model and compare
   task automatic step(input logic w, input logic [7:0] d, input logic r);
      logic full_pre;
      logic empty_pre;
      logic wa;
      logic ra;
      logic [7:0] tmp;
      bus_std.wr_en = w;
      bus_std.d_in  = d;
      bus_std.rd_en = r;
      bus_fw.wr_en  = w;
      bus_fw.d_in   = d;
      bus_fw.rd_en  = r;
      @(posedge clk);
      // standard: popped word appears on d_out after the accepting edge
      full_pre  = (q_std.size() == DEPTH);
      empty_pre = (q_std.size() == 0);
      wa = w && !full_pre;
      ra = r && !empty_pre;
      ovf_std = w && full_pre;
      unf_std = r && empty_pre;
      if (ra) dout_std = q_std.pop_front();
      if (wa) q_std.push_back(d);
      // FWFT: a word is shown once it was stored before the current edge
      full_pre  = (q_fw.size() == DEPTH);
      empty_pre = !shown_fw;
      wa = w && !full_pre;
      ra = r && !empty_pre;
      ovf_fw = w && full_pre;
      unf_fw = r && empty_pre;
      if (ra) tmp = q_fw.pop_front();
      shown_fw = (q_fw.size() > 0);
      if (shown_fw) dout_fw = q_fw[0];
      if (wa) q_fw.push_back(d);
      #1;
      check_all();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int guard;
      bus_std.wr_en = 1'b0; bus_std.rd_en = 1'b0; bus_std.d_in = '0;
      bus_fw.wr_en  = 1'b0; bus_fw.rd_en  = 1'b0; bus_fw.d_in  = '0;
      model_reset();

      // asynchronous reset, observed before any clock edge
      #1 rst = 1'b1;
      #2 check_reset_values();
      @(negedge clk) rst = 1'b0;

      // three writes, three reads
      step(1'b1, 8'h11, 1'b0);
      step(1'b1, 8'h22, 1'b0);
      step(1'b1, 8'h33, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      check_eq("seq_first", 32'(bus_std.d_out), 32'h11);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      check_eq("seq_last", 32'(bus_std.d_out), 32'h33);
      step(1'b0, 8'h00, 1'b0);

      // fill to full, then one write too many
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
      check_eq("fill_full", 32'(bus_std.full), 1);
      step(1'b1, 8'hEE, 1'b0);
      check_eq("fill_ovf", 32'(bus_std.overflow), 1);

      // simultaneous read/write while full
      step(1'b1, 8'hCC, 1'b1);
      check_eq("full_rw_dout", 32'(bus_std.d_out), 32'h00);
      check_eq("full_rw_count", 32'(bus_std.count), DEPTH - 1);
      step(1'b0, 8'h00, 1'b1);
      check_eq("full_next_read", 32'(bus_std.d_out), 32'h01);

      // drain, underflow on empty, then simultaneous access on empty
      guard = 0;
      while ((q_std.size() > 0 || shown_fw) && guard < 2 * DEPTH) begin
         step(1'b0, 8'h00, 1'b1);
         guard++;
      end
      check_eq("drain_bound", 32'(guard < 2 * DEPTH), 1);
      step(1'b0, 8'h00, 1'b1);
      check_eq("empty_rd_unf", 32'(bus_std.underflow), 1);
      step(1'b1, 8'hA5, 1'b1);
      check_eq("empty_rw_count", 32'(bus_std.count), 1);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      check_eq("empty_rw_data", 32'(bus_std.d_out), 32'hA5);
      step(1'b0, 8'h00, 1'b1);

      // FWFT fall-through latency
      step(1'b1, 8'h5A, 1'b0);
      check_eq("fwft_n_empty", 32'(bus_fw.empty), 1);
      step(1'b0, 8'h00, 1'b0);
      check_eq("fwft_n1_dout", 32'(bus_fw.d_out), 32'h5A);
      check_eq("fwft_n1_empty", 32'(bus_fw.empty), 0);
      step(1'b0, 8'h00, 1'b1);
      check_eq("fwft_pop_count", 32'(bus_fw.count), 0);

      // random interleaved traffic with wraparound
      for (int i = 0; i < 260; i++) begin
         step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45);
      end

      // reset mid-stream
      rst = 1'b1;
      #2 check_reset_values();
      model_reset();
      @(negedge clk) rst = 1'b0;
      bus_std.wr_en = 1'b0; bus_std.rd_en = 1'b0;
      bus_fw.wr_en  = 1'b0; bus_fw.rd_en  = 1'b0;

      for (int i = 0; i < 150; i++) begin
         step($urandom_range(0, 99) < 50, 8'($urandom), $urandom_range(0, 99) < 50);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W words (32).
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-4, count at or above which almost_full asserts.
REQ-004 The block SHALL have parameter AE_LEVEL, default 4, count at or below which almost_empty asserts.
REQ-005 The block SHALL have parameter FWFT, default 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through.
REQ-006 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst, input, 1, reset; one clock, reset asynchronous and active-high.
REQ-008 The block SHALL have port wr_en, input, 1, write request.
REQ-009 The block SHALL have port d_in, input, DATA_W, write data.
REQ-010 The block SHALL have port rd_en, input, 1, read request (standard) or pop/acknowledge (FWFT).
REQ-011 The block SHALL have port d_out, output, DATA_W, registered read data.
REQ-012 The block SHALL have port full, output, 1, count == DEPTH.
REQ-013 The block SHALL have port empty, output, 1, no readable word.
REQ-014 The block SHALL have port almost_full, output, 1, count >= AF_LEVEL.
REQ-015 The block SHALL have port almost_empty, output, 1, count <= AE_LEVEL.
REQ-016 The block SHALL have port count, output, ADDR_W+1, current occupancy, 0..DEPTH.
REQ-017 The block SHALL have port overflow, output, 1, one-cycle pulse: wr_en while full.
REQ-018 The block SHALL have port underflow, output, 1, one-cycle pulse: rd_en while empty.

Function
REQ-019 Write accepted iff wr_en && !full; d_in stored at wr_ptr, wr_ptr increments mod DEPTH.
REQ-020 Read accepted iff rd_en && !empty; rejected requests SHALL change no pointer, count, or d_out.
REQ-021 Pointers SHALL be ADDR_W+1 bits binary with wrap bit; full/empty distinguished by wrap bit when addresses equal.
REQ-022 count SHALL increment on accepted write only, decrement on accepted read only, hold when both or neither accepted.
REQ-023 full, empty, almost_full, almost_empty, count SHALL be registered and reflect all edges up to and including the current one (no extra lag).
REQ-024 Standard mode: accepted read at edge N SHALL present the head word on d_out after edge N; d_out holds otherwise.
REQ-025 Standard mode: a write at edge N into an empty FIFO SHALL deassert empty after edge N.
REQ-026 FWFT mode: d_out SHALL show the head word whenever empty=0, without rd_en; rd_en with empty=0 pops it and loads next word (or sets empty) after that edge.
REQ-027 FWFT mode: a write at edge N into an empty FIFO SHALL present the word on d_out with empty=0 after edge N+1; count includes the word held in d_out.
REQ-028 Capacity SHALL be DEPTH words in both modes.
REQ-029 Simultaneous write and read when full: read accepted, write rejected, overflow pulses, count becomes DEPTH-1.
REQ-030 Simultaneous write and read when empty: write accepted, read rejected, underflow pulses, count becomes 1.
REQ-031 overflow/underflow SHALL be single-cycle registered pulses, asserted after the edge where the rejected request was sampled.
REQ-032 Pointer wrap past DEPTH-1 SHALL be seamless; ordering strictly first-in first-out.

Reset
REQ-033 rst=1 SHALL immediately, without clk, clear pointers, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, d_out=0.
REQ-034 Reset mid-operation SHALL discard all stored words; memory contents need not be cleared.
REQ-035 First accepted write SHALL be possible at the first rising edge after rst deasserts.

Verification
REQ-036 Standard: reset, write 0x11,0x22,0x33, read 3 -> d_out 0x11,0x22,0x33 one cycle after each read edge; empty=1, count=0 at end.
REQ-037 Fill 32 writes 0x00..0x1F -> full=1 and count=32 after 32nd edge; almost_full=1 from count=28; 33rd write -> overflow pulse, count stays 32.
REQ-038 Full + simultaneous wr/rd -> d_out=0x00, count=31, overflow=1 one cycle; next read returns 0x01.
REQ-039 Empty + rd_en -> underflow=1 one cycle, count=0, d_out unchanged; empty + simultaneous wr 0xA5/rd -> count=1, underflow=1.
REQ-040 FWFT=1: write 0x5A at edge N -> d_out=0x5A, empty=0 after edge N+1, no rd_en; rd_en one cycle -> empty=1, count=0.
REQ-041 Wrap: 100 interleaved writes/reads with random gaps -> output sequence equals input; assert rst mid-stream -> flags at reset values immediately.
